// File: rtl/jtkicker_prog_router_if.sv
// Download-side bus of the program router: ioctl byte stream in, SDRAM and PROM
// programming requests out, plus status.
interface jtkicker_prog_router_if #(
  parameter int AW = 25,
  parameter int PW = 22
) ();
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wr;
  logic [PW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          sdram_ack;
  logic          prom_we;
  logic [10:0]   prom_addr;
  logic [7:0]    prom_data;
  logic          dwnld_busy;
  logic          overflow;

  modport slave (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we,
    output prom_we, prom_addr, prom_data, dwnld_busy, overflow
  );

  modport master (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we,
    input  prom_we, prom_addr, prom_data, dwnld_busy, overflow
  );
endinterface

// File: rtl/jtkicker_prog_router.sv
// Routes the ioctl ROM download into up to three swizzled SDRAM regions through a
// write FIFO, and into a PROM region through a directly registered strobe.
module jtkicker_prog_router #(
  parameter int          AW         = 25,
  parameter int          PW         = 22,
  parameter int          DEPTH      = 4,
  parameter logic [21:0] R1_START   = 22'h0,
  parameter logic [21:0] R2_START   = 22'h0,
  parameter logic [21:0] R3_START   = 22'h0,
  parameter logic [24:0] PROM_START = 25'h0,
  parameter int          R1_MODE    = 1,
  parameter int          R2_MODE    = 2
) (
  input logic                   clk,
  input logic                   rstn,
  jtkicker_prog_router_if.slave bus
);
  localparam int             PTRW = $clog2(DEPTH);
  localparam int             CW   = PTRW + 1;
  localparam int             EW   = PW + 10;
  localparam logic [AW-1:0]  R1_A   = AW'(R1_START);
  localparam logic [AW-1:0]  R2_A   = AW'(R2_START);
  localparam logic [AW-1:0]  R3_A   = AW'(R3_START);
  localparam logic [AW-1:0]  PROM_A = AW'(PROM_START);
  localparam logic [1:0]     M1     = 2'(R1_MODE);
  localparam logic [1:0]     M2     = 2'(R2_MODE);
  localparam logic [CW-1:0]  CNT0   = {CW{1'b0}};
  localparam logic [CW-1:0]  FULL   = CW'(DEPTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Only the low six address bits are ever permuted; higher bits pass straight through.
  function automatic logic [5:0] swz6(input logic [5:0] a, input logic [1:0] mode);
    logic [5:0] s;
    s = a;
    case (mode)
      2'd1:    s = {a[5:4], a[2:0], ~a[3]};
      2'd2:    s = {a[5], a[2:0], ~a[4], ~a[3]};
      default: s = a;
    endcase
    return s;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [PTRW-1:0]   r_wr_ptr;
  logic [PTRW-1:0]   r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_busy;
  logic [PW-1:0]     r_prog_addr;
  logic [15:0]       r_prog_data;
  logic [1:0]        r_prog_mask;
  logic              r_prog_we;
  logic              r_prom_we;
  logic [10:0]       r_prom_addr;
  logic [7:0]        r_prom_data;

  logic              w_is_prom;
  logic [1:0]        w_mode;
  logic [5:0]        w_sw;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;
  logic              w_wr;
  logic              w_push_req;
  logic              w_prom_wr;
  logic [10:0]       w_prom_off;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;

  // Region decode, highest region first
  always_comb begin
    w_is_prom = 1'b0;
    w_mode    = 2'd0;
    if (bus.ioctl_addr >= PROM_A) begin
      w_is_prom = 1'b1;
    end else if (bus.ioctl_addr >= R3_A) begin
      w_mode = 2'd0;
    end else if (bus.ioctl_addr >= R2_A) begin
      w_mode = M2;
    end else if (bus.ioctl_addr >= R1_A) begin
      w_mode = M1;
    end else begin
      w_mode = 2'd0;
    end
  end

  // FIFO entry: {word address, active-low mask, byte}
  always_comb begin
    w_sw       = swz6(bus.ioctl_addr[5:0], w_mode);
    w_entry    = {bus.ioctl_addr[PW:6], w_sw[5:1], (w_sw[0] ? 2'b01 : 2'b10), bus.ioctl_dout};
    w_head     = r_mem[r_rd_ptr];
    w_wr       = bus.ioctl_wr & bus.downloading;
    w_push_req = w_wr & ~w_is_prom;
    w_prom_wr  = w_wr & w_is_prom;
    w_prom_off = bus.ioctl_addr[10:0] - PROM_A[10:0];
  end

  // Request FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = (r_count != CNT0) ? ST_WAIT : ST_IDLE;
      ST_WAIT: w_state_nxt = bus.sdram_ack ? ST_IDLE : ST_WAIT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request FSM outputs; a full FIFO still accepts a push when it pops in the same cycle
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = (r_count != CNT0);
      ST_WAIT: w_pop = 1'b0;
      default: w_pop = 1'b0;
    endcase
    w_push_ok = w_push_req & ((r_count != FULL) | w_pop);
    w_drop    = w_push_req & ~w_push_ok;
  end

  // FIFO storage, data only
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_entry;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= {PTRW{1'b0}};
      r_rd_ptr   <= {PTRW{1'b0}};
      r_count    <= CNT0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTRW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // SDRAM request registers, held stable until acknowledged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prog_we   <= 1'b0;
      r_prog_addr <= {PW{1'b0}};
      r_prog_data <= 16'h0000;
      r_prog_mask <= 2'b11;
    end else if (w_pop) begin
      r_prog_we   <= 1'b1;
      r_prog_addr <= w_head[EW-1:10];
      r_prog_mask <= w_head[9:8];
      r_prog_data <= {w_head[7:0], w_head[7:0]};
    end else if ((r_state == ST_WAIT) && bus.sdram_ack) begin
      r_prog_we   <= 1'b0;
    end
  end

  // PROM strobe bypasses the FIFO; busy covers the tail of the last request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prom_we   <= 1'b0;
      r_prom_addr <= 11'h000;
      r_prom_data <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_prom_we <= w_prom_wr;
      if (w_prom_wr) begin
        r_prom_addr <= w_prom_off;
        r_prom_data <= bus.ioctl_dout;
      end
      r_busy <= bus.downloading | (r_count != CNT0) | r_prog_we;
    end
  end

  assign bus.prog_addr  = r_prog_addr;
  assign bus.prog_data  = r_prog_data;
  assign bus.prog_mask  = r_prog_mask;
  assign bus.prog_we    = r_prog_we;
  assign bus.prom_we    = r_prom_we;
  assign bus.prom_addr  = r_prom_addr;
  assign bus.prom_data  = r_prom_data;
  assign bus.dwnld_busy = r_busy;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_jtkicker_prog_router.sv
// Directed and randomized checks of jtkicker_prog_router against a region/swizzle
// reference model and an in-order write scoreboard.
module tb_jtkicker_prog_router;
  localparam int AW = 25;
  localparam int PW = 22;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  jtkicker_prog_router_if #(.AW(AW), .PW(PW)) bus ();

  jtkicker_prog_router #(
    .AW(AW), .PW(PW), .DEPTH(4),
    .R1_START(22'h004000), .R2_START(22'h008000), .R3_START(22'h00C000),
    .PROM_START(25'h0010000), .R1_MODE(1), .R2_MODE(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  logic prev_we = 1'b0;

  // every rising prog_we is one new SDRAM write
  always @(negedge clk) begin
    if (rstn && bus.prog_we && !prev_we)
      obs_q.push_back({bus.prog_addr, bus.prog_mask, bus.prog_data});
    prev_we <= bus.prog_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // region map: <0x4000 plain, <0x8000 tile, <0xC000 obj, <0x10000 plain
  function automatic logic [39:0] ref_entry(input logic [24:0] a, input logic [7:0] d);
    logic [24:0] s;
    int mode;
    mode = (a >= 25'h000C000) ? 0 : (a >= 25'h0008000) ? 2 : (a >= 25'h0004000) ? 1 : 0;
    s = a;
    if (mode == 1) begin
      s[0] = ~a[3]; s[1] = a[0]; s[2] = a[1]; s[3] = a[2];
    end else if (mode == 2) begin
      s[0] = ~a[3]; s[1] = ~a[4]; s[2] = a[0]; s[3] = a[1]; s[4] = a[2]; s[5] = a[5];
    end
    return {s[22:1], (s[0] ? 2'b01 : 2'b10), d, d};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic sdram_one(input string tag, input logic [24:0] a, input logic [7:0] d,
                           input logic [21:0] w, input logic [1:0] m);
    bus.sdram_ack  = 1'b0;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    cyc();
    bus.ioctl_wr   = 1'b0;
    chk({tag, "_we_n1"}, bus.prog_we, 1'b0);
    bus.sdram_ack  = 1'b1;
    cyc();
    chk({tag, "_we_n2"}, bus.prog_we, 1'b1);
    chk({tag, "_addr"}, bus.prog_addr, w);
    chk({tag, "_mask"}, bus.prog_mask, m);
    chk({tag, "_data"}, bus.prog_data, {d, d});
    chk({tag, "_model"}, {bus.prog_addr, bus.prog_mask, bus.prog_data}, ref_entry(a, d));
    cyc();
    chk({tag, "_we_fall"}, bus.prog_we, 1'b0);
    bus.sdram_ack  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] a;
    logic [7:0]  d;
    int          r;
    int          sz;
    int          last_we;
    logic        we_hist [30];
    logic        busy_hist [30];

    rstn = 1'b0;
    bus.downloading = 1'b0;
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_addr  = 25'h0;
    bus.ioctl_dout  = 8'h00;
    bus.sdram_ack   = 1'b0;
    cyc(); cyc();
    chk("rst_prog_we", bus.prog_we, 1'b0);
    chk("rst_mask", bus.prog_mask, 2'b11);
    chk("rst_addr", bus.prog_addr, 22'h0);
    chk("rst_prom_we", bus.prom_we, 1'b0);
    chk("rst_busy", bus.dwnld_busy, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    rstn = 1'b1;
    bus.downloading = 1'b1;
    cyc(); cyc();
    chk("busy_dl", bus.dwnld_busy, 1'b1);

    // writes are ignored when not downloading
    bus.downloading = 1'b0;
    bus.ioctl_addr = 25'h0004008; bus.ioctl_dout = 8'h11; bus.ioctl_wr = 1'b1;
    cyc();
    bus.ioctl_wr = 1'b0;
    cyc(); cyc();
    chk("ign_we", bus.prog_we, 1'b0);
    bus.downloading = 1'b1;
    cyc();

    sdram_one("r1_a", 25'h0004008, 8'hA5, 22'h002000, 2'b10);
    sdram_one("r1_b", 25'h0004001, 8'h5A, 22'h002001, 2'b01);
    sdram_one("r2_a", 25'h0008018, 8'hC3, 22'h004000, 2'b10);
    sdram_one("bnd_7fff", 25'h0007FFF, 8'h77, 22'h003FFF, 2'b10);
    sdram_one("bnd_8000", 25'h0008000, 8'h80, 22'h004001, 2'b01);
    sdram_one("r0", 25'h0000009, 8'h09, 22'h000004, 2'b01);
    sdram_one("r3", 25'h000C00C, 8'h0C, 22'h006006, 2'b10);

    // PROM bypass
    cyc();
    sz = obs_q.size();
    bus.ioctl_addr = 25'h0010123; bus.ioctl_dout = 8'h3C; bus.ioctl_wr = 1'b1;
    cyc();
    bus.ioctl_wr = 1'b0;
    chk("prom_we", bus.prom_we, 1'b1);
    chk("prom_addr", bus.prom_addr, 11'h123);
    chk("prom_data", bus.prom_data, 8'h3C);
    chk("prom_no_prog", bus.prog_we, 1'b0);
    cyc();
    chk("prom_pulse", bus.prom_we, 1'b0);
    cyc(); cyc();
    chk("prom_no_prog2", bus.prog_we, 1'b0);
    chk("prom_no_sdram", obs_q.size(), sz);

    // overflow: six back-to-back writes with ack held low
    obs_q.delete(); exp_q.delete();
    bus.sdram_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 25'h0004000 + 25'(i * 9);
      d = 8'($urandom);
      if (i < 5) exp_q.push_back(ref_entry(a, d));
      bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
      cyc();
    end
    bus.ioctl_wr = 1'b0;
    chk("ovf_flag", bus.overflow, 1'b1);
    chk("ovf_wait_we", bus.prog_we, 1'b1);
    chk("ovf_wait_one", obs_q.size(), 1);
    chk("ovf_hold", {bus.prog_addr, bus.prog_mask, bus.prog_data}, exp_q[0]);
    bus.sdram_ack = 1'b1;
    for (int i = 0; i < 40 && obs_q.size() < 5; i++) cyc();
    cyc(); cyc(); cyc();
    chk("ovf_count", obs_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("ovf_order", (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
    chk("ovf_sticky", bus.overflow, 1'b1);

    // reset with one request waiting and three queued
    bus.sdram_ack = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.ioctl_addr = 25'(i * 2); bus.ioctl_dout = 8'(i); bus.ioctl_wr = 1'b1;
      cyc();
    end
    bus.ioctl_wr = 1'b0;
    chk("rmid_we_pre", bus.prog_we, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rmid_we", bus.prog_we, 1'b0);
    chk("rmid_mask", bus.prog_mask, 2'b11);
    chk("rmid_ovf", bus.overflow, 1'b0);
    obs_q.delete();
    cyc();
    rstn = 1'b1;
    bus.sdram_ack = 1'b1;
    repeat (6) cyc();
    chk("rmid_nowr", obs_q.size(), 0);
    chk("rmid_busy", bus.dwnld_busy, 1'b1);

    // downloading falls with two entries queued
    bus.sdram_ack = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 2; i++) begin
      bus.ioctl_addr = 25'h0008000 + 25'(i); bus.ioctl_dout = 8'hE0 + 8'(i); bus.ioctl_wr = 1'b1;
      cyc();
    end
    bus.ioctl_wr = 1'b0;
    bus.downloading = 1'b0;
    bus.sdram_ack = 1'b1;
    last_we = -1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      we_hist[i] = bus.prog_we;
      busy_hist[i] = bus.dwnld_busy;
      if (bus.prog_we) last_we = i;
    end
    chk("dl_writes", obs_q.size(), 2);
    if (last_we >= 0 && last_we < 28) begin
      chk("dl_we_fell", we_hist[last_we + 1], 1'b0);
      chk("dl_busy_hold", busy_hist[last_we + 1], 1'b1);
      chk("dl_busy_fall", busy_hist[last_we + 2], 1'b0);
    end else begin
      chk("dl_we_seen", last_we, 3);
    end
    bus.downloading = 1'b1;
    bus.sdram_ack = 1'b0;
    cyc();

    // randomized mix across every region, ack always present
    obs_q.delete(); exp_q.delete();
    bus.sdram_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0:       a = 25'($urandom_range(0, 32'h3FFF));
        1:       a = 25'h0004000 + 25'($urandom_range(0, 32'h3FFF));
        2:       a = 25'h0008000 + 25'($urandom_range(0, 32'h3FFF));
        3:       a = 25'h000C000 + 25'($urandom_range(0, 32'h3FFF));
        default: a = 25'h0010000 + 25'($urandom_range(0, 32'hFFFF));
      endcase
      d = 8'($urandom);
      bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
      cyc();
      bus.ioctl_wr = 1'b0;
      if (r == 4) begin
        chk("rnd_prom_we", bus.prom_we, 1'b1);
        chk("rnd_prom", {bus.prom_addr, bus.prom_data}, {11'(a - 25'h0010000), d});
      end else begin
        exp_q.push_back(ref_entry(a, d));
      end
      repeat ($urandom_range(1, 3)) cyc();
    end
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) cyc();
    cyc(); cyc(); cyc();
    chk("rnd_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("rnd_entry", (i < obs_q.size()) ? obs_q[i] : 40'h0, exp_q[i]);
    chk("rnd_no_ovf", bus.overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
